// File: rtl/spi_mem_bridge_pkg.sv
// Shared types and sizing helpers for the SPI-to-parameter-memory bridge.
// Optional frame error output is enabled by defining SPI_FRAME_ERR_EN.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    READ   = 2'd2,
    WRITE  = 2'd3
  } bridge_state_e;

  function automatic int word_bits(input int param_width, input int pad_bits);
    return param_width + pad_bits;
  endfunction

  function automatic int cnt_width(input int wbits);
    return $clog2(wbits);
  endfunction

  // The read/write flag sits in the MSB of the header word.
  function automatic int hdr_w_bit(input int wbits);
    return wbits - 1;
  endfunction

endpackage

// File: rtl/spi_mem_bridge_if.sv
// Memory-side bus of the SPI bridge: synchronous-read port plus a strobed write port.
interface spi_mem_bridge_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PARAM_WIDTH = 36
) ();

  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic [PARAM_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [PARAM_WIDTH-1:0] wr_data;
  logic                   wr_enable;

  modport master (
    output rd_addr, wr_addr, wr_data, wr_enable,
    input  rd_data
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, wr_enable,
    output rd_data
  );

endinterface

// File: rtl/spi_mem_bridge_shift_engine.sv
// SPI bit engine: SCLK edge detect, bit counter, MOSI deserialiser, MISO serialiser.
// Inputs are already synchronised to clk; everything idles cleared while inactive.
module spi_shift_engine
  import spi_bridge_pkg::*;
#(
  parameter int WORD_BITS = 40,
  parameter int LOAD_BITS = 36,
  parameter bit CPOL      = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sclk_i,
  input  logic                 mosi_i,
  input  logic                 active_i,
  input  logic                 load_req_i,
  input  logic [LOAD_BITS-1:0] load_data_i,
  output logic                 word_done_o,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 mid_word_o,
  output logic                 miso_o
);

  localparam int                CW      = cnt_width(WORD_BITS);
  localparam logic [CW-1:0]     CNT_TOP = CW'(WORD_BITS - 1);

  logic                 sclk_n;
  logic                 sclk_prev_q;
  logic                 lead_edge;
  logic                 trail_edge;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_BITS-1:0] in_sr_q, in_sr_d;
  logic [WORD_BITS-1:0] out_sr_q, out_sr_d;
  logic                 load_pend_q, load_pend_d;
  logic                 unused_in_msb;

  // Normalise polarity so the leading edge is always a 0->1 transition of sclk_n.
  assign sclk_n     = sclk_i ^ CPOL;
  assign lead_edge  = sclk_n & ~sclk_prev_q;
  assign trail_edge = ~sclk_n & sclk_prev_q;

  assign word_done_o   = active_i & lead_edge & (cnt_q == '0);
  assign word_o        = {in_sr_q[WORD_BITS-2:0], mosi_i};
  assign mid_word_o    = (cnt_q != CNT_TOP);
  assign miso_o        = out_sr_q[WORD_BITS-1];
  assign unused_in_msb = in_sr_q[WORD_BITS-1];

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned, which would infer a latch.
    cnt_d       = cnt_q;
    in_sr_d     = in_sr_q;
    out_sr_d    = out_sr_q;
    load_pend_d = load_pend_q;
    if (!active_i) begin
      cnt_d       = CNT_TOP;
      in_sr_d     = '0;
      out_sr_d    = '0;
      load_pend_d = 1'b0;
    end else begin
      if (lead_edge) begin
        in_sr_d = {in_sr_q[WORD_BITS-2:0], mosi_i};
        if (cnt_q == '0) begin
          cnt_d       = CNT_TOP;
          load_pend_d = load_req_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // The trailing edge after a completed read word reloads instead of shifting.
      if (trail_edge) begin
        if (load_pend_q) begin
          out_sr_d    = WORD_BITS'(load_data_i);
          load_pend_d = 1'b0;
        end else begin
          out_sr_d = {out_sr_q[WORD_BITS-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q <= 1'b0;
      cnt_q       <= CNT_TOP;
      in_sr_q     <= '0;
      out_sr_q    <= '0;
      load_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      sclk_prev_q <= sclk_n;
      cnt_q       <= cnt_d;
      in_sr_q     <= in_sr_d;
      out_sr_q    <= out_sr_d;
      load_pend_q <= load_pend_d;
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave bridging burst reads/writes (header + auto-increment) to the parameter RAM.
// Define SPI_FRAME_ERR_EN to add the frame_err output (pulse on a truncated word).
module spi_mem_bridge
  import spi_bridge_pkg::*;
#(
  parameter int PARAM_WIDTH = 36,
  parameter int ADDR_WIDTH  = 8,
  parameter int PAD_BITS    = 4,
  parameter bit CPOL        = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_SSEL,
  input  logic              spi_MOSI,
  output logic              spi_MISO,
  spi_mem_bridge_if.master  mem,
  output logic              busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  localparam int WORD_BITS = word_bits(PARAM_WIDTH, PAD_BITS);
  localparam int HDR_W_BIT = hdr_w_bit(WORD_BITS);

  logic [2:0]             sync1_q, sync2_q;
  logic                   sclk_s, ssel_s, mosi_s;
  logic                   armed_q;
  bridge_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [PARAM_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   load_req;
  logic                   word_done;
  logic [WORD_BITS-1:0]   word;
  logic                   mid_word;
  logic                   unused_bits;

  assign {sclk_s, ssel_s, mosi_s} = sync2_q;

  spi_shift_engine #(
    .WORD_BITS (WORD_BITS),
    .LOAD_BITS (PARAM_WIDTH),
    .CPOL      (CPOL)
  ) u_engine (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk_i      (sclk_s),
    .mosi_i      (mosi_s),
    .active_i    (state_q != IDLE),
    .load_req_i  (load_req),
    .load_data_i (mem.rd_data),
    .word_done_o (word_done),
    .word_o      (word),
    .mid_word_o  (mid_word),
    .miso_o      (spi_MISO)
  );

`ifdef SPI_FRAME_ERR_EN
  logic ssel_prev_q;
  logic frame_err_q, frame_err_d;
  assign frame_err   = frame_err_q;
  assign frame_err_d = ssel_s & ~ssel_prev_q & (state_q != IDLE) & mid_word;
  assign unused_bits = ^word;
`else
  assign unused_bits = ^{word, mid_word};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      ptr_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      ssel_prev_q <= 1'b0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= {spi_SCLK, spi_SSEL, spi_MOSI};
      sync2_q   <= sync1_q;
      // Synchronisers reset low, so wait for a real SSEL-high before trusting a low.
      armed_q   <= armed_q | ssel_s;
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
`ifdef SPI_FRAME_ERR_EN
      ssel_prev_q <= ssel_s;
      frame_err_q <= frame_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (armed_q && !ssel_s) state_d = HEADER;
      HEADER:  if (word_done) state_d = word[HDR_W_BIT] ? WRITE : READ;
      default: state_d = state_q;
    endcase
    if (ssel_s) state_d = IDLE;
  end

  always_comb begin
    ptr_d     = ptr_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    load_req  = 1'b0;
    // A word finishing in the same cycle SSEL rises is treated as partial and dropped.
    if (word_done && !ssel_s) begin
      unique case (state_q)
        HEADER: begin
          ptr_d = word[ADDR_WIDTH-1:0];
          if (!word[HDR_W_BIT]) begin
            rd_addr_d = word[ADDR_WIDTH-1:0];
            load_req  = 1'b1;
          end
        end
        READ: begin
          ptr_d     = ptr_q + 1'b1;
          rd_addr_d = ptr_q + 1'b1;
          load_req  = 1'b1;
        end
        WRITE: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = word[PARAM_WIDTH-1:0];
          ptr_d     = ptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign mem.rd_addr   = rd_addr_q;
  assign mem.wr_addr   = wr_addr_q;
  assign mem.wr_data   = wr_data_q;
  assign mem.wr_enable = wr_en_q;

endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
Parametrised SPI slave that bridges an external SPI master to the on-chip parameter memory. Supports both burst read and burst write with a command/address header and an auto-incrementing address. SCLK polarity is configurable. It replaces the read-only streaming SPI slave: it adds an explicit start address and a driven write port, and it sits between the control MCU's SPI bus and the dual-port coefficient RAM.

Parameters:
- PARAM_WIDTH, 36, memory word width in bits.
- ADDR_WIDTH, 8, memory address width in bits; must be ≤ WORD_BITS-1.
- PAD_BITS, 4, zero pad bits above the data; WORD_BITS = PARAM_WIDTH+PAD_BITS (default 40).
- CPOL, 0, SCLK idle level. Leading edge is rising when CPOL=0 and falling when CPOL=1. Phase is fixed: sample on the leading edge, shift on the trailing edge.

Ports:
- clk, in, 1, system clock; the only clock.
- reset_n, in, 1, asynchronous active-low reset.
- spi_SCLK, in, 1, SPI clock; asynchronous to clk.
- spi_SSEL, in, 1, slave select, active-low; asynchronous.
- spi_MOSI, in, 1, SPI data in, MSB first.
- spi_MISO, out, 1, SPI data out, MSB first.
- rd_addr, out, ADDR_WIDTH, memory read address; synchronous read, 1-cycle latency.
- rd_data, in, PARAM_WIDTH, memory read data.
- wr_addr, out, ADDR_WIDTH, memory write address.
- wr_data, out, PARAM_WIDTH, memory write data.
- wr_enable, out, 1, single-cycle write strobe.
- busy, out, 1, high while a transaction is open (state not IDLE).

Behaviour:
- Input synchronisation: SCLK, SSEL and MOSI each pass through the existing 2-flop synchroniser. Edges are detected against the previous synchronised SCLK.
- Reset values: all outputs 0; state IDLE; pointer 0; shift registers 0.
- Timing requirement: SCLK half-period ≥ 4 clk.
- Frame format: every transaction is one header word followed by N data words, each WORD_BITS long.
- Header word: bit WORD_BITS-1 = W (1 = write, 0 = read); bits [ADDR_WIDTH-1:0] = start address A; all other bits ignored.
- States:
  - IDLE → HEADER when synchronised SSEL is low.
  - HEADER → READ or WRITE on header-word completion, chosen by W.
  - Any state → IDLE whenever synchronised SSEL is high.
- After reset, the block leaves IDLE only after it has seen synchronised SSEL high at least once.
- Bit counter: counts from WORD_BITS-1 down to 0, decrementing on each leading edge. At 0 it reloads WORD_BITS-1 and flags word completion in that same cycle.
- Pointer arithmetic: the pointer wraps modulo 2^ADDR_WIDTH (0xFF+1 = 0x00).
- WRITE state: on each data-word completion:
  - next cycle: wr_enable=1 for exactly 1 clk, wr_addr=pointer, wr_data=word[PARAM_WIDTH-1:0]; pad bits are discarded.
  - pointer increments in that same cycle.
  - MISO shifts zeros.
- READ state:
  - at header completion: pointer=A and rd_addr=A.
  - at each data-word completion: pointer+1 and rd_addr=pointer+1.
  - rd_data is captured 1 clk after rd_addr changes.
  - on the trailing edge that follows word completion, the output register is loaded with {PAD zeros, rd_data} instead of shifting.
  - result: data word k carries mem[A+k].
  - no writes occur in READ.
- HEADER state: MISO outputs 0.
- MISO always equals the MSB of the output register. The register shifts left on every trailing edge except load edges.
- SSEL deasserts mid-word: the partial word is discarded, no write occurs, return to IDLE. Any write strobe already issued stands.
- Reset asserted mid-transaction: all state clears immediately and no strobe is produced.

Optional Feature:
- Macro SPI_FRAME_ERR_EN.
- When defined: adds output port frame_err (1 bit, reset 0). It pulses for 1 clk on the SSEL rising edge if the bit counter ≠ WORD_BITS-1, i.e. a partial word was received. This includes a truncated header.
- When undefined: the port is absent and partial words are silently discarded.

Decomposition:
- Package spi_bridge_pkg holds:
  - state enum {IDLE, HEADER, READ, WRITE};
  - localparam functions for WORD_BITS and the counter width ($clog2(WORD_BITS));
  - the header field position HDR_W_BIT.
- Natural sub-module: spi_shift_engine (edge detect, bit counter, input/output shift registers, word-done and load interface). The parent holds the FSM, pointer and memory ports.

Test Plan:
- Write burst: header 0x80_0000_0010 followed by data words 0x1_2345_6789 and 0xF_FFFF_FFFF → two single-cycle wr_enable strobes, wr_addr 0x10 then 0x11, wr_data 0x1_2345_6789 then 0xF_FFFF_FFFF.
- Read burst with wrap: mem[0xFE]=0xA, mem[0xFF]=0xB, mem[0x00]=0xC; header 0x00_0000_00FE, then 3 data words → MISO returns 0x00_0000_000A, 0x..0B, 0x..0C; rd_addr wraps to 0x00; wr_enable never asserts.
- SSEL raised after 20 bits of the second data word in a write → exactly one write (first word); busy low within 3 clk; with SPI_FRAME_ERR_EN, frame_err pulses once.
- Reset asserted mid-read with SSEL held low → outputs 0, busy 0, no activity until SSEL goes high and then low; the next transaction then behaves normally.
- CPOL=1 build: repeat the write-burst scenario with inverted SCLK → identical wr_addr, wr_data and strobe count.
- Back-to-back transactions, SSEL high for only 4 clk between them → the second header is decoded correctly from bit 0 and the pointer restarts at its address.
